lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter SHALL be: TIMEOUT, default 255, cycles allowed in REQ+WAIT before a timeout error (range 2..65535).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  asynchronous, active-low reset
  in_valid  in  1  upstream access request valid
  in_ready  out  1  lsu_ctrl accepts request
  in_wr  in  1  1 = store, 0 = load
  in_op  in  3  MemOp: 000 b signed, 001 h signed, 010 w, 100 bu, 101 hu
  in_addr  in  32  byte address
  in_wdata  in  32  store data, right-aligned
  mem_valid  out  1  memory request valid
  mem_ready  in  1  memory accepts request
  mem_addr  out  32  word-aligned address
  mem_wen  out  1  request is a write
  mem_wdata  out  32  lane-shifted store data
  mem_wmask  out  4  byte-lane write mask
  mem_rvalid  in  1  memory response/ack valid
  mem_rdata  in  32  raw read word
  out_valid  out  1  result valid to writeback
  out_ready  in  1  writeback accepts result
  out_data  out  32  extended load data; 0 for stores and errors
  out_err  out  2  00 ok, 01 misaligned, 10 illegal op, 11 timeout

Function
REQ-003 FSM SHALL have states IDLE, REQ, WAIT, RESP; in_ready = 1 only in IDLE.
REQ-004 IDLE, in_valid=1: inputs SHALL be latched; illegal op (011, 110, 111; or store with 100/101) -> RESP, err 10; else misaligned (h with addr[0]=1; w with addr[1:0]!=0) -> RESP, err 01; else -> REQ. Illegal SHALL take priority over misaligned.
REQ-005 Erroneous requests SHALL never assert mem_valid.
REQ-006 REQ: mem_valid=1, mem_addr/mem_wen/mem_wdata/mem_wmask SHALL be stable until mem_ready=1; handshake -> WAIT.
REQ-007 mem_addr SHALL be {addr[31:2],2'b00}; byte store: wdata = in_wdata[7:0] in lane addr[1:0], mask = 1<<addr[1:0]; half store: in_wdata[15:0] in lanes addr[1]*2..+1, mask 0011/1100; word: mask 1111; loads: mem_wmask=0000, mem_wdata=0.
REQ-008 WAIT: mem_rvalid=1 SHALL complete the access (store: ack; load: capture) -> RESP, err 00.
REQ-009 Load data SHALL be selected by latched addr[1:0] (byte lane or half lane) and sign-extended (000, 001) or zero-extended (100, 101); 010 passes the word.
REQ-010 A cycle counter SHALL clear on entering REQ and increment each cycle in REQ or WAIT; on reaching TIMEOUT -> RESP, err 11, out_data 0.
REQ-011 mem_rvalid in the same cycle the counter reaches TIMEOUT SHALL win (normal completion).
REQ-012 mem_rvalid outside WAIT SHALL be ignored; a late response after timeout SHALL not alter out_data or state.
REQ-013 RESP: out_valid=1, out_data/out_err stable until out_ready=1 -> IDLE; no new request accepted in that cycle.
REQ-014 Minimum latency: accept at cycle 0, mem_ready=1 in cycle 1, mem_rvalid=1 in cycle 2 -> out_valid in cycle 3.
REQ-015 All outputs SHALL be registered or decoded solely from state and latched registers (no in_* -> out_* combinational path).

Reset
REQ-016 rst_n=0 SHALL immediately force IDLE, counter 0, in_ready=1, mem_valid=0, mem_wen=0, mem_wmask=0, mem_addr=0, mem_wdata=0, out_valid=0, out_data=0, out_err=00.
REQ-017 Reset mid-access SHALL abandon the transaction; subsequent mem_rvalid SHALL be ignored per REQ-012.

Verification
REQ-018 Load op=000 addr=0x80000003, mem_rdata=0x80112233 -> mem_addr=0x80000000, out_data=0xFFFFFF80, err 00, out_valid in cycle 3 with zero memory wait.
REQ-019 Store op=001 addr=0x80000102 wdata=0x0000BEEF -> mem_addr=0x80000100, mem_wdata=0xBEEF0000, mem_wmask=1100; after ack out_data=0, err 00.
REQ-020 Load op=010 addr=0x80000006 -> no mem_valid, err 01; store op=100 -> err 10; op=011 at misaligned addr -> err 10.
REQ-021 TIMEOUT=4, mem_ready=1, mem_rvalid held 0 -> err 11 after 4 cycles; mem_rvalid pulsed one cycle later ignored; separately mem_rvalid on the 4th cycle -> err 00.
REQ-022 mem_ready held 0 for 3 cycles, out_ready held 0 for 2 cycles -> mem_* and out_* stable throughout; rst_n low during WAIT -> REQ-016 values next observation.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one byte/half/word access, checks legality and
// alignment, runs a single memory request/response handshake with a cycle timeout, and
// returns extended load data (or zero for stores and errors) with a 2-bit status code.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wr,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

  localparam logic [1:0] ErrOk       = 2'b00;
  localparam logic [1:0] ErrMisalign = 2'b01;
  localparam logic [1:0] ErrIllegal  = 2'b10;
  localparam logic [1:0] ErrTimeout  = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] out_data_q, out_data_d;
  logic [1:0]  out_err_q, out_err_d;

  logic        illegal;
  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [15:0] cnt_inc;

  // Classify the incoming request: illegal encodings first, then alignment.
  always_comb begin
    illegal = 1'b0;
    case (in_op)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b100, 3'b101:         illegal = in_wr;  // unsigned variants are load-only
      default:                illegal = 1'b0;
    endcase
    misaligned = 1'b0;
    case (in_op)
      3'b001, 3'b101: misaligned = in_addr[0];
      3'b010:         misaligned = |in_addr[1:0];
      default:        misaligned = 1'b0;
    endcase
  end

  // Shift store data into its byte lanes and build the matching write mask.
  always_comb begin
    st_wdata = in_wdata;
    st_wmask = 4'b1111;
    case (in_op[1:0])
      2'b00: begin
        st_wdata = {24'h0, in_wdata[7:0]} << {in_addr[1:0], 3'b000};
        st_wmask = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        st_wdata = {16'h0, in_wdata[15:0]} << {in_addr[1], 4'b0000};
        st_wmask = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = in_wdata;
        st_wmask = 4'b1111;
      end
    endcase
  end

  // Pick the addressed lane of the returned word and extend it.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (lane_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state logic for the access FSM, timeout counter and latched request/result.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    lane_d      = lane_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    cnt_inc     = cnt_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d       = in_op;
          lane_d     = in_addr[1:0];
          out_data_d = 32'h0;
          if (illegal) begin
            state_d   = RESP;
            out_err_d = ErrIllegal;
          end else if (misaligned) begin
            state_d   = RESP;
            out_err_d = ErrMisalign;
          end else begin
            state_d     = REQ;
            cnt_d       = 16'h0;
            out_err_d   = ErrOk;
            mem_addr_d  = {in_addr[31:2], 2'b00};
            mem_wen_d   = in_wr;
            mem_wdata_d = in_wr ? st_wdata : 32'h0;
            mem_wmask_d = in_wr ? st_wmask : 4'b0000;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (cnt_inc == TimeoutVal) begin
          state_d    = RESP;
          out_err_d  = ErrTimeout;
          out_data_d = 32'h0;
        end else if (mem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A response arriving on the final allowed cycle still completes normally.
        if (mem_rvalid) begin
          state_d    = RESP;
          out_err_d  = ErrOk;
          out_data_d = mem_wen_q ? 32'h0 : ld_data;
        end else if (cnt_inc == TimeoutVal) begin
          state_d    = RESP;
          out_err_d  = ErrTimeout;
          out_data_d = 32'h0;
        end
      end
      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and latched registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 16'h0;
      op_q        <= 3'b000;
      lane_q      <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= 32'h0;
      mem_wmask_q <= 4'b0000;
      out_data_q  <= 32'h0;
      out_err_q   <= ErrOk;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  // Outputs come only from state and registers; no input reaches an output directly.
  always_comb begin
    in_ready  = (state_q == IDLE);
    mem_valid = (state_q == REQ);
    out_valid = (state_q == RESP);
    mem_addr  = mem_addr_q;
    mem_wen   = mem_wen_q;
    mem_wdata = mem_wdata_q;
    mem_wmask = mem_wmask_q;
    out_data  = out_data_q;
    out_err   = out_err_q;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a reference model predicts memory requests and results, which are
// queued at issue and compared when the DUT produces them. A second instance with a short
// timeout is selected for the timeout scenarios.
module tb_lsu_ctrl;

  localparam int TO_T = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } mem_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  err;
  } res_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_wr = 1'b0;
  logic [2:0]  in_op = 3'b000;
  logic [31:0] in_addr = 32'h0;
  logic [31:0] in_wdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_ready = 1'b0;
  logic        use_t = 1'b0;

  logic        m_in_ready, m_mem_valid, m_mem_wen, m_out_valid;
  logic [31:0] m_mem_addr, m_mem_wdata, m_out_data;
  logic [3:0]  m_mem_wmask;
  logic [1:0]  m_out_err;
  logic        t_in_ready, t_mem_valid, t_mem_wen, t_out_valid;
  logic [31:0] t_mem_addr, t_mem_wdata, t_out_data;
  logic [3:0]  t_mem_wmask;
  logic [1:0]  t_out_err;

  logic        s_in_ready, s_mem_valid, s_mem_wen, s_out_valid;
  logic [31:0] s_mem_addr, s_mem_wdata, s_out_data;
  logic [3:0]  s_mem_wmask;
  logic [1:0]  s_out_err;

  assign s_in_ready  = use_t ? t_in_ready  : m_in_ready;
  assign s_mem_valid = use_t ? t_mem_valid : m_mem_valid;
  assign s_mem_wen   = use_t ? t_mem_wen   : m_mem_wen;
  assign s_mem_addr  = use_t ? t_mem_addr  : m_mem_addr;
  assign s_mem_wdata = use_t ? t_mem_wdata : m_mem_wdata;
  assign s_mem_wmask = use_t ? t_mem_wmask : m_mem_wmask;
  assign s_out_valid = use_t ? t_out_valid : m_out_valid;
  assign s_out_data  = use_t ? t_out_data  : m_out_data;
  assign s_out_err   = use_t ? t_out_err   : m_out_err;

  lsu_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(m_in_ready), .in_wr(in_wr), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_valid(m_mem_valid), .mem_ready(mem_ready), .mem_addr(m_mem_addr),
    .mem_wen(m_mem_wen), .mem_wdata(m_mem_wdata), .mem_wmask(m_mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data), .out_err(m_out_err)
  );

  lsu_ctrl #(.TIMEOUT(TO_T)) u_dut_t (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(t_in_ready), .in_wr(in_wr), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_valid(t_mem_valid), .mem_ready(mem_ready), .mem_addr(t_mem_addr),
    .mem_wen(t_mem_wen), .mem_wdata(t_mem_wdata), .mem_wmask(t_mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data), .out_err(t_out_err)
  );

  always #5 clk = ~clk;

  mem_exp_t mem_q[$];
  res_exp_t res_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  mem_exp_t me0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model(input logic wr, input logic [2:0] op,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, output logic go,
                                output mem_exp_t me, output res_exp_t re);
    logic [7:0]  b;
    logic [15:0] h;
    logic        ill, mis;
    ill = (op == 3'b011) || (op == 3'b110) || (op == 3'b111) ||
          (wr && ((op == 3'b100) || (op == 3'b101)));
    mis = (((op == 3'b001) || (op == 3'b101)) && addr[0]) ||
          ((op == 3'b010) && (addr[1:0] != 2'b00));
    go = !ill && !mis;
    me.addr  = {addr[31:2], 2'b00};
    me.wen   = wr;
    me.wdata = 32'h0;
    me.mask  = 4'b0000;
    re.err   = ill ? 2'b10 : (mis ? 2'b01 : 2'b00);
    re.data  = 32'h0;
    case (addr[1:0])
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    if (go && wr) begin
      case (op)
        3'b000: begin
          case (addr[1:0])
            2'd0:    begin me.wdata = {24'h0, wdata[7:0]};        me.mask = 4'b0001; end
            2'd1:    begin me.wdata = {16'h0, wdata[7:0], 8'h0};  me.mask = 4'b0010; end
            2'd2:    begin me.wdata = {8'h0, wdata[7:0], 16'h0};  me.mask = 4'b0100; end
            default: begin me.wdata = {wdata[7:0], 24'h0};        me.mask = 4'b1000; end
          endcase
        end
        3'b001: begin
          if (addr[1]) begin me.wdata = {wdata[15:0], 16'h0}; me.mask = 4'b1100; end
          else         begin me.wdata = {16'h0, wdata[15:0]}; me.mask = 4'b0011; end
        end
        default: begin me.wdata = wdata; me.mask = 4'b1111; end
      endcase
    end else if (go) begin
      case (op)
        3'b000:  re.data = {{24{b[7]}}, b};
        3'b100:  re.data = {24'h0, b};
        3'b001:  re.data = {{16{h[15]}}, h};
        3'b101:  re.data = {16'h0, h};
        default: re.data = rdata;
      endcase
    end
  endfunction

  task automatic reset_vals();
    chk("rst_in_ready", s_in_ready, 1);
    chk("rst_mem_valid", s_mem_valid, 0);
    chk("rst_mem_wen", s_mem_wen, 0);
    chk("rst_mem_wmask", s_mem_wmask, 0);
    chk("rst_mem_addr", s_mem_addr, 0);
    chk("rst_mem_wdata", s_mem_wdata, 0);
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_out_data", s_out_data, 0);
    chk("rst_out_err", s_out_err, 0);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
  initial begin : mon
    mem_exp_t e, pm;
    res_exp_t r, po;
    bit p_mem, p_out;
    p_mem = 0;
    p_out = 0;
    pm = '0;
    po = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_mem = 0;
        p_out = 0;
      end else begin
        if (p_mem) begin
          chk("mem_valid_hold", s_mem_valid, 1);
          chk("mem_addr_hold", s_mem_addr, pm.addr);
          chk("mem_wen_hold", s_mem_wen, pm.wen);
          chk("mem_wdata_hold", s_mem_wdata, pm.wdata);
          chk("mem_wmask_hold", s_mem_wmask, pm.mask);
        end
        if (p_out) begin
          chk("out_valid_hold", s_out_valid, 1);
          chk("out_data_hold", s_out_data, po.data);
          chk("out_err_hold", s_out_err, po.err);
        end
        if (s_mem_valid && mem_ready) begin
          if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
          else begin
            e = mem_q.pop_front();
            chk("mem_addr", s_mem_addr, e.addr);
            chk("mem_wen", s_mem_wen, e.wen);
            chk("mem_wdata", s_mem_wdata, e.wdata);
            chk("mem_wmask", s_mem_wmask, e.mask);
          end
        end
        if (s_out_valid && out_ready) begin
          if (res_q.size() == 0) chk("res_unexpected", 1, 0);
          else begin
            r = res_q.pop_front();
            chk("out_data", s_out_data, r.data);
            chk("out_err", s_out_err, r.err);
          end
        end
        p_mem = s_mem_valid && !mem_ready;
        pm    = '{s_mem_addr, s_mem_wen, s_mem_wdata, s_mem_wmask};
        p_out = s_out_valid && !out_ready;
        po    = '{s_out_data, s_out_err};
      end
    end
  end

  // One complete access: issue, play memory with the given stalls, accept the result.
  task automatic access(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int mem_stall, input int rsp_delay, input int out_stall,
                        input bit to, input int late_cyc);
    mem_exp_t me;
    res_exp_t re;
    logic     go;
    int       exp_lat, hs_cyc, out_cyc;
    bit       got_hs, seen, done;
    hs_cyc = 0; out_cyc = 0; got_hs = 0; seen = 0; done = 0;
    model(wr, op, addr, wdata, rdata, go, me, re);
    if (go && to) begin
      re.data = 32'h0;
      re.err  = 2'b11;
    end
    if (go) mem_q.push_back(me);
    res_q.push_back(re);
    exp_lat = !go ? 1 : (to ? TO_T + 1 : 3 + mem_stall + rsp_delay);
    @(posedge clk); #1;
    in_valid = 1'b1; in_wr = wr; in_op = op; in_addr = addr; in_wdata = wdata;
    @(negedge clk);
    chk("in_ready_idle", s_in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_wr = ~wr;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      mem_ready  = !got_hs && (cyc > mem_stall);
      mem_rvalid = (got_hs && (cyc == hs_cyc + 1 + rsp_delay)) || (cyc == late_cyc);
      mem_rdata  = (got_hs && (cyc == hs_cyc + 1 + rsp_delay)) ? rdata : $urandom;
      out_ready  = seen && (cyc > out_cyc + out_stall);
      @(negedge clk);
      if (s_mem_valid && mem_ready) begin got_hs = 1; hs_cyc = cyc; end
      if (s_out_valid && !seen) begin
        seen = 1;
        out_cyc = cyc;
        chk("latency", cyc, exp_lat);
      end
      if (s_out_valid && out_ready) begin
        chk("in_ready_resp", s_in_ready, 0);
        done = 1;
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b0;
    if (!done) chk("resp_handshake", 0, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_vals();
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed vectors
    access(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h8011_2233, 0, 0, 0, 0, 0);
    access(1'b1, 3'b001, 32'h8000_0102, 32'h0000_BEEF, 32'h0, 0, 0, 0, 0, 0);
    access(1'b0, 3'b010, 32'h8000_0006, 32'h0, 32'h1111_1111, 0, 0, 0, 0, 0);
    access(1'b1, 3'b100, 32'h8000_0001, 32'h55, 32'h0, 0, 0, 0, 0, 0);
    access(1'b0, 3'b011, 32'h8000_0003, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    access(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h9234_8765, 3, 1, 2, 0, 0);
    access(1'b1, 3'b000, 32'h8000_0011, 32'hA5, 32'h0, 3, 0, 2, 0, 0);
    access(1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h9234_8765, 0, 0, 1, 0, 0);
    access(1'b0, 3'b100, 32'h8000_0001, 32'h0, 32'h0000_F000, 1, 0, 0, 0, 0);

    // Random mix including illegal and misaligned requests
    for (int i = 0; i < 16; i++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), 0, 0);
    end

    // Reset during WAIT abandons the access; a stale response is ignored
    me0 = '{32'h8000_0040, 1'b0, 32'h0, 4'b0000};
    mem_q.push_back(me0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_wr = 1'b0; in_op = 3'b010; in_addr = 32'h8000_0040;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("stale_rsp_out_valid", s_out_valid, 0);
    chk("stale_rsp_in_ready", s_in_ready, 1);
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stale_rsp_out_valid2", s_out_valid, 0);

    // Timeout scenarios on the short-timeout instance
    @(posedge clk); #1 rst_n = 1'b0; use_t = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0, 100, 2, 1, TO_T + 1);
    @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("idle_rsp_out_valid", s_out_valid, 0);
    chk("idle_rsp_in_ready", s_in_ready, 1);
    @(posedge clk); #1 mem_rvalid = 1'b0;
    access(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 0, 2, 0, 0, 0);
    access(1'b1, 3'b010, 32'h0000_0108, 32'h0BAD_CAFE, 32'h0, 0, 100, 1, 1, 0);

    chk("scoreboard_empty", mem_q.size() + res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
